// File: rtl/tff_count_ctrl.sv
// Controller for a bank of WIDTH toggle stages forming an up/down counter with pause, abort and terminal-count done.
// Optional: define TFF_COUNT_CTRL_AUTORELOAD_EN to reload and keep running at terminal count instead of returning to IDLE.
module tff_count_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic [WIDTH-1:0] r_limit;
    logic [WIDTH-1:0] w_limit_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_busy;
    logic [WIDTH-1:0] w_t_vec;
    logic [WIDTH-1:0] w_adv_t;
    logic [WIDTH-1:0] w_reload;
    logic             w_carry;
    logic             w_terminal;

    // Ripple toggle enables: a stage flips when every lower stage is 1 (up) or 0 (down).
    always_comb begin
        w_adv_t    = '0;
        w_carry    = 1'b1;
        w_adv_t[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            w_carry    = w_carry & (r_dir ? ~r_q[i-1] : r_q[i-1]);
            w_adv_t[i] = w_carry;
        end
    end

    assign w_terminal = r_dir ? (r_q == '0) : (r_q == r_limit);
    assign w_reload   = r_dir ? r_limit : '0;

    // Next-state, next-count and toggle-enable decode.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_dir_nxt   = r_dir;
        w_limit_nxt = r_limit;
        w_done_nxt  = 1'b0;
        w_t_vec     = '0;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_dir_nxt   = dir;
                    w_limit_nxt = limit;
                    w_q_nxt     = dir ? limit : '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (pause) begin
                    w_state_nxt = ST_HOLD;
                end else if (w_terminal) begin
                    w_done_nxt = 1'b1;
`ifdef TFF_COUNT_CTRL_AUTORELOAD_EN
                    w_t_vec = r_q ^ w_reload;
                    w_q_nxt = r_q ^ w_t_vec;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end else begin
                    w_t_vec = w_adv_t;
                    w_q_nxt = r_q ^ w_adv_t;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (!pause) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Nothing toggles in a cycle that reset is about to override.
        if (rst) begin
            w_t_vec = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_dir   <= 1'b0;
            r_limit <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_dir   <= w_dir_nxt;
            r_limit <= w_limit_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign t_vec = w_t_vec;
    assign q     = r_q;
    assign qbar  = ~r_q;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Scoreboard bench for tff_count_ctrl: directed per-cycle vectors push expected outputs, a negedge monitor compares.
module tb_tff_count_ctrl;

    localparam int unsigned WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
        logic [WIDTH-1:0] t_vec;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic             dir;
    logic [WIDTH-1:0] limit;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             busy;
    logic             done;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    tff_count_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .dir   (dir),
        .limit (limit),
        .pause (pause),
        .abort (abort),
        .t_vec (t_vec),
        .q     (q),
        .qbar  (qbar),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: drive inputs just after the edge, expect the outputs visible during that cycle.
    task automatic cyc(input logic i_rst, input logic i_start, input logic i_dir,
                       input logic [WIDTH-1:0] i_lim, input logic i_pause, input logic i_abort,
                       input logic [WIDTH-1:0] e_q, input logic e_busy, input logic e_done,
                       input logic [WIDTH-1:0] e_t);
        exp_t e;
        @(posedge clk);
        #1;
        rst   = i_rst;
        start = i_start;
        dir   = i_dir;
        limit = i_lim;
        pause = i_pause;
        abort = i_abort;
        e.q     = e_q;
        e.busy  = e_busy;
        e.done  = e_done;
        e.t_vec = e_t;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if (q !== e.q || qbar !== ~e.q || busy !== e.busy || done !== e.done || t_vec !== e.t_vec) begin
                miscompares++;
                $display("FAIL vec%0d t=%0t: got q=%h qbar=%h busy=%b done=%b t_vec=%h, want q=%h qbar=%h busy=%b done=%b t_vec=%h",
                         vectors, $time, q, qbar, busy, done, t_vec, e.q, ~e.q, e.busy, e.done, e.t_vec);
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        start = 1'b0;
        dir   = 1'b0;
        limit = '0;
        pause = 1'b0;
        abort = 1'b0;

        //  rst st dir lim   pa ab |  q     busy done t_vec
        cyc(1, 0, 0, 4'd0, 0, 0,   4'd0, 0, 0, 4'h0);
`ifndef TFF_COUNT_CTRL_AUTORELOAD_EN
        // Up to 5; limit/dir/start changes while busy must be ignored.
        cyc(0, 1, 0, 4'd5, 0, 0,   4'd0, 0, 0, 4'h0);
        cyc(0, 0, 0, 4'd9, 0, 0,   4'd0, 1, 0, 4'h1);
        cyc(0, 0, 1, 4'd0, 0, 0,   4'd1, 1, 0, 4'h3);
        cyc(0, 1, 1, 4'd0, 0, 0,   4'd2, 1, 0, 4'h1);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd3, 1, 0, 4'h7);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd4, 1, 0, 4'h1);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd5, 1, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd5, 0, 1, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd5, 0, 0, 4'h0);
        // Down from 3.
        cyc(0, 1, 1, 4'd3, 0, 0,   4'd5, 0, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd3, 1, 0, 4'h1);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd2, 1, 0, 4'h3);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd1, 1, 0, 4'h1);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd0, 1, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd0, 0, 1, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd0, 0, 0, 4'h0);
        // Up to 5 with two paused edges at q=2; HOLD exit adds a third frozen edge.
        cyc(0, 1, 0, 4'd5, 0, 0,   4'd0, 0, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd0, 1, 0, 4'h1);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd1, 1, 0, 4'h3);
        cyc(0, 0, 0, 4'd0, 1, 0,   4'd2, 1, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 1, 0,   4'd2, 1, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd2, 1, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd2, 1, 0, 4'h1);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd3, 1, 0, 4'h7);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd4, 1, 0, 4'h1);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd5, 1, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd5, 0, 1, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd5, 0, 0, 4'h0);
        // Reset mid-run at q=3, then start accepted in the first post-reset cycle.
        cyc(0, 1, 0, 4'd7, 0, 0,   4'd5, 0, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd0, 1, 0, 4'h1);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd1, 1, 0, 4'h3);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd2, 1, 0, 4'h1);
        cyc(1, 1, 0, 4'd0, 1, 1,   4'd3, 1, 0, 4'h0);
        cyc(0, 1, 0, 4'd2, 0, 0,   4'd0, 0, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd0, 1, 0, 4'h1);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd1, 1, 0, 4'h3);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd2, 1, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd2, 0, 1, 4'h0);
        // limit=0 up: done one edge after entry.
        cyc(0, 1, 0, 4'd0, 0, 0,   4'd2, 0, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd0, 1, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd0, 0, 1, 4'h0);
        // Abort at q=2 (abort beats pause), no done.
        cyc(0, 1, 0, 4'd7, 0, 0,   4'd0, 0, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd0, 1, 0, 4'h1);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd1, 1, 0, 4'h3);
        cyc(0, 0, 0, 4'd0, 1, 1,   4'd2, 1, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd2, 0, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd2, 0, 0, 4'h0);
        // Abort from HOLD.
        cyc(0, 1, 1, 4'd6, 0, 0,   4'd2, 0, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 1, 0,   4'd6, 1, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 1, 1,   4'd6, 1, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd6, 0, 0, 4'h0);
`else
        // Autoreload up to 2: 0,1,2,0,1,2 with done every third cycle until abort.
        cyc(0, 1, 0, 4'd2, 0, 0,   4'd0, 0, 0, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd0, 1, 0, 4'h1);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd1, 1, 0, 4'h3);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd2, 1, 0, 4'h2);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd0, 1, 1, 4'h1);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd1, 1, 0, 4'h3);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd2, 1, 0, 4'h2);
        cyc(0, 0, 0, 4'd0, 0, 1,   4'd0, 1, 1, 4'h0);
        cyc(0, 0, 0, 4'd0, 0, 0,   4'd0, 0, 0, 4'h0);
`endif

        for (int i = 0; i < 4 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
